ifu_prefetch_queue: RTL and testbench
=====================================

// Module: ifu_prefetch_queue
// PURPOSE
//  Parametrised instruction fetch unit with prefetch buffer; successor to the single-PC fetch stage.
//  Owns the PC and issues sequential fetches over a valid/ready memory request port.
//  Buffers returned instructions with their PCs in a DEPTH-entry FIFO toward decode (valid/ready).
//  Redirect (branch/jump) flushes the queue, discards any in-flight response and restarts at the new PC.
// PARAMETERS
//  XLEN      32   PC / address / instruction width
//  DEPTH     4    prefetch queue entries; power of two, >= 2
//  RESET_PC  0    PC loaded on reset
//  PC_STEP   4    byte increment per sequential fetch; power of two
// PORTS
//  clk            in   1                  rising-edge clock
//  reset          in   1                  asynchronous, active-low reset
//  pc_update      in   1                  redirect request (1-cycle pulse or held)
//  pc_new         in   XLEN               redirect target; low log2(PC_STEP) bits forced to 0
//  mem_req_valid  out  1                  fetch request valid
//  mem_req_ready  in   1                  memory accepts request
//  mem_req_addr   out  XLEN               fetch address (= pc)
//  mem_rsp_valid  in   1                  response data valid (one per accepted request, any latency >= 1)
//  mem_rsp_data   in   XLEN               fetched instruction
//  out_valid      out  1                  queue head valid
//  out_ready      in   1                  decode consumes head
//  out_instr      out  XLEN               head instruction
//  out_pc         out  XLEN               head instruction PC
//  pc             out  XLEN               next fetch PC
//  count          out  $clog2(DEPTH)+1    queue occupancy
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_PC, state=IDLE, queue empty, count=0, out_valid=0, mem_req_valid=0.
//  At most one request outstanding. mem_req_valid = (state==REQ). mem_req_addr = pc.
//  FSM:
//   IDLE: count<DEPTH -> REQ; else stay.
//   REQ:  mem_req_ready=1 -> req_pc<=pc, pc<=pc+PC_STEP (wraps mod 2^XLEN), -> WAIT.
//   WAIT: mem_rsp_valid=1 -> push {req_pc, mem_rsp_data}; -> REQ if count_next<DEPTH, else IDLE.
//   DROP: mem_rsp_valid=1 -> discard data, -> REQ.
//  Redirect (pc_update=1) has priority over every other transition in the same cycle:
//   - pc<=pc_new (aligned); queue flushed (count=0, out_valid=0 next cycle); a same-cycle pop is ignored.
//   - IDLE/REQ, request not accepted: -> REQ; mem_req_addr=pc_new next cycle. An unaccepted request may be
//     abandoned. Outside a redirect, valid and address stay stable until ready.
//   - REQ with mem_req_ready=1 (accepted), or WAIT without rsp: -> DROP.
//   - WAIT with mem_rsp_valid=1: response discarded, -> REQ.
//   - DROP: stay DROP until the pending response, pc still updated; DROP+rsp+redirect -> REQ.
//  Queue: push only from WAIT on rsp. A request is issued only when count<DEPTH, so the queue cannot overflow.
//   Pop when out_valid && out_ready. Push and pop in the same cycle: count unchanged, order preserved.
//  Latency: request accepted at t, rsp at r>t -> out_valid at r+1 with out_pc=req_pc. Redirect at t ->
//   first request at pc_new on t+1 (from IDLE/REQ). Back-to-back zero-wait memory: one instruction per 2 cycles.
//  Outputs out_instr/out_pc come from the registered FIFO head; they are don't-care when out_valid=0.
// TESTING
//  1 Reset: hold reset=0 20ns, release; memory 1-cycle response with mem[a]=a/4+1; out_ready=1 ->
//    out_pc 0,4,8,12,16 with out_instr 1,2,3,4,5 in order.
//  2 Backpressure: out_ready=0 -> count saturates at DEPTH=4, mem_req_valid=0 in IDLE; then out_ready=1 ->
//    no lost or duplicate PCs, fetch resumes at 16.
//  3 Redirect in WAIT: pc_update=1, pc_new=128 while a rsp for PC 8 is pending -> the PC 8 rsp is dropped,
//    queue flushed, next out_pc=128, then 132.
//  4 Redirect with same-cycle rsp, and redirect with same-cycle request accept -> no stale entry in the
//    queue; first queued PC = pc_new.
//  5 Misaligned and wrap: pc_new=32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then 0.
//  6 Async reset mid-fetch (WAIT, count=2): out_valid, mem_req_valid and count drop immediately without
//    a clock edge; the late rsp after release is ignored.

Source files
------------

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch unit: owns the PC, issues one sequential fetch at a time and
// buffers returned instructions with their PCs in a small FIFO toward decode.
module ifu_prefetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pc_update,
    input  logic [XLEN-1:0]            pc_new,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [XLEN-1:0]            mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [XLEN-1:0]            mem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
    localparam logic [CW-1:0]   FULL       = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t          state;
    state_t          state_d;
    logic [XLEN-1:0] req_pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = pc;
    assign out_valid     = (count != '0);
    assign out_instr     = instr_mem[rd_ptr];
    assign out_pc        = pc_mem[rd_ptr];

    // A redirect flushes the queue, so neither a push nor a pop may land in that cycle.
    always_comb begin
        push       = (state == WAIT) && mem_rsp_valid && !pc_update;
        pop        = out_valid && out_ready && !pc_update;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (count < FULL) state_d = REQ;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: if (mem_rsp_valid) state_d = (count_next < FULL) ? REQ : IDLE;
            DROP: if (mem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase
        // An accepted-but-unanswered request must have its response swallowed in DROP.
        if (pc_update) begin
            case (state)
                IDLE:    state_d = REQ;
                REQ:     state_d = mem_req_ready ? DROP : REQ;
                WAIT:    state_d = mem_rsp_valid ? REQ : DROP;
                DROP:    state_d = mem_rsp_valid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_d;
            if (pc_update) begin
                pc     <= pc_new & ALIGN_MASK;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (state == REQ && mem_req_ready) begin
                    req_pc <= pc;
                    pc     <= pc + STEP;
                end
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_next;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rsp_data;
            pc_mem[wr_ptr]    <= req_pc;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: directed scenarios push expected
// {pc, instr} pairs, a monitor pops and compares on every decode handshake.
module tb_ifu_prefetch_queue;

    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic          pc_update;
    logic [31:0]   pc_new;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   pc;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   mem_latency = 1;
    bit   mem_keep    = 1'b0;

    ifu_prefetch_queue #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_update(pc_update), .pc_new(pc_new),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .pc(pc), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: mem[a] = a/4 + 1, answered mem_latency cycles after acceptance.
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [31:0] a;
        logic [31:0] pa;
        acc = 1'b0; pend = 1'b0; cnt = 0; a = '0; pa = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc = mem_req_valid && mem_req_ready && reset;
            a   = mem_req_addr;
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (!reset && !mem_keep) pend = 1'b0;
            if (acc) begin
                pend = 1'b1;
                cnt  = mem_latency;
                pa   = a;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = (pa >> 2) + 32'd1;
                    pend          = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expectEntry(input logic [31:0] epc, input logic [31:0] einstr);
        exp_q.push_back('{pc: epc, instr: einstr});
    endtask

    // Single-cycle redirect pulse, launched and released just after a rising edge.
    task automatic applyStimulus(input logic [31:0] target);
        pc_update = 1'b1;
        pc_new    = target;
        @(posedge clk);
        #1;
        pc_update = 1'b0;
    endtask

    task automatic applyReset();
        reset         = 1'b0;
        pc_update     = 1'b0;
        out_ready     = 1'b0;
        mem_req_ready = 1'b1;
        mem_latency   = 1;
        mem_keep      = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        pc_update     = 1'b0;
        pc_new        = '0;
        out_ready     = 1'b0;
        mem_req_ready = 1'b1;

        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (reset && out_valid && out_ready && !pc_update) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_pop: actual out_pc=%h out_instr=%h required no output",
                                     out_pc, out_instr);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("sb_out_pc", out_pc, e.pc);
                            checkOutput("sb_out_instr", out_instr, e.instr);
                        end
                    end
                end
            end
        join_none

        // Reset state and in-order sequential fetch
        $display("[TB] test 1: reset and sequential fetch");
        out_ready = 1'b1;
        #17;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_pc", pc, 32'h0);
        expectEntry(32'd0, 32'd1);
        expectEntry(32'd4, 32'd2);
        expectEntry(32'd8, 32'd3);
        expectEntry(32'd12, 32'd4);
        expectEntry(32'd16, 32'd5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitDrain("t1_drain");

        $display("[TB] test 2: backpressure");
        applyReset();
        n = 0;
        while (count != 3'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t2_count_full", 32'(count), 32'd4);
        checkOutput("t2_req_idle", 32'(mem_req_valid), 32'd0);
        checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_resume_pc", pc, 32'd16);
        expectEntry(32'd0, 32'd1);
        expectEntry(32'd4, 32'd2);
        expectEntry(32'd8, 32'd3);
        expectEntry(32'd12, 32'd4);
        expectEntry(32'd16, 32'd5);
        expectEntry(32'd20, 32'd6);
        out_ready = 1'b1;
        waitDrain("t2_drain");

        $display("[TB] test 3: redirect while waiting");
        applyReset();
        mem_latency = 3;
        out_ready   = 1'b1;
        expectEntry(32'd0, 32'd1);
        expectEntry(32'd4, 32'd2);
        expectEntry(32'd128, 32'd33);
        expectEntry(32'd132, 32'd34);
        n = 0;
        while (!(pc == 32'd12 && !mem_req_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t3_wait_pc8", pc, 32'd12);
        applyStimulus(32'd128);
        checkOutput("t3_flush_count", 32'(count), 32'd0);
        checkOutput("t3_flush_valid", 32'(out_valid), 32'd0);
        checkOutput("t3_new_pc", pc, 32'd128);
        checkOutput("t3_drop_no_req", 32'(mem_req_valid), 32'd0);
        waitDrain("t3_drain");

        $display("[TB] test 4a: redirect with same-cycle response");
        applyReset();
        mem_latency = 2;
        out_ready   = 1'b1;
        expectEntry(32'd256, 32'd65);
        expectEntry(32'd260, 32'd66);
        n = 0;
        while (!(pc == 32'd4 && !mem_req_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        applyStimulus(32'd256);
        checkOutput("t4a_req_valid", 32'(mem_req_valid), 32'd1);
        checkOutput("t4a_req_addr", mem_req_addr, 32'd256);
        checkOutput("t4a_count", 32'(count), 32'd0);
        waitDrain("t4a_drain");

        $display("[TB] test 4b: redirect with same-cycle accept");
        applyReset();
        out_ready = 1'b1;
        expectEntry(32'd512, 32'd129);
        expectEntry(32'd516, 32'd130);
        n = 0;
        while (!mem_req_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        applyStimulus(32'd512);
        checkOutput("t4b_drop_no_req", 32'(mem_req_valid), 32'd0);
        checkOutput("t4b_new_pc", pc, 32'd512);
        waitDrain("t4b_drain");

        $display("[TB] test 5: misaligned target and wrap");
        applyReset();
        out_ready = 1'b1;
        expectEntry(32'hFFFF_FFFC, 32'h4000_0000);
        expectEntry(32'h0000_0000, 32'h0000_0001);
        applyStimulus(32'hFFFF_FFFE);
        checkOutput("t5_req_valid", 32'(mem_req_valid), 32'd1);
        checkOutput("t5_aligned_addr", mem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        checkOutput("t5_wrap_pc", pc, 32'h0);
        waitDrain("t5_drain");

        $display("[TB] test 6: async reset mid-fetch");
        applyReset();
        n = 0;
        while (count != 3'd2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        mem_latency = 4;
        n = 0;
        while (!(pc == 32'd12 && !mem_req_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t6_pre_count", 32'(count), 32'd2);
        checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
        mem_keep = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_async_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("t6_async_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_late_rsp_count", 32'(count), 32'd0);
        checkOutput("t6_late_rsp_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_req_addr", mem_req_addr, 32'd0);
        mem_keep      = 1'b0;
        mem_latency   = 1;
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        expectEntry(32'd0, 32'd1);
        expectEntry(32'd4, 32'd2);
        waitDrain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
